// File: rtl/uaslr_rekey_ctrl.sv
// Live uASLR rekey sequencer: halts the core, waits for the instruction and data
// buses to drain, then swaps in a fresh LFSR-derived offset and releases the core.
module uaslr_rekey_ctrl #(
  parameter int unsigned          RNG_WIDTH       = 32,
  parameter int unsigned          PERIOD_WIDTH    = 16,
  parameter int unsigned          MAX_OUTSTANDING = 4,
  parameter logic [RNG_WIDTH-1:0] LFSR_SEED       = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_enable_i,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
  input  logic                    rekey_req_i,
  input  logic                    seed_load_i,
  input  logic [RNG_WIDTH-1:0]    seed_i,
  input  logic                    instr_req_i,
  input  logic                    instr_gnt_i,
  input  logic                    instr_rvalid_i,
  input  logic                    data_req_i,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  output logic                    halt_req_o,
  input  logic                    halt_ack_i,
  output logic [RNG_WIDTH-1:0]    uaslr_config_o,
  output logic                    rekey_done_o,
  output logic                    busy_o,
  output logic [7:0]              epoch_o
);

  localparam int unsigned          CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [RNG_WIDTH-1:0] LFSR_TAPS = RNG_WIDTH'(32'h8020_0003);

  typedef enum logic [1:0] {ST_IDLE, ST_HALT, ST_APPLY, ST_RESUME} state_e;

  state_e                  state_q, state_d;
  logic [RNG_WIDTH-1:0]    lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]        instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0]        data_cnt_q, data_cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    pending_q, pending_d;
  logic [RNG_WIDTH-1:0]    config_q, config_d;
  logic [7:0]              epoch_q, epoch_d;
  logic                    done_q, done_d;
  logic                    period_on, auto_fire, trigger, drained;

  // Simultaneous issue and response cancel; the count clamps at both ends.
  function automatic logic [CNT_W-1:0] outst_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec && cnt < CNT_MAX) r = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0) r = cnt - CNT_W'(1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    period_on = cfg_enable_i && (cfg_period_i != '0);
    auto_fire = (state_q == ST_IDLE) && period_on &&
                (period_q == cfg_period_i - PERIOD_WIDTH'(1));
    trigger   = (state_q == ST_IDLE) && (rekey_req_i || pending_q || auto_fire);
    // Registered counts: a response landing with the ack only counts next cycle.
    drained   = (instr_cnt_q == '0) && (data_cnt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trigger) state_d = ST_HALT;
      ST_HALT:   if (halt_ack_i && drained) state_d = ST_APPLY;
      ST_APPLY:  state_d = ST_RESUME;
      ST_RESUME: if (!halt_ack_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    halt_req_o = 1'b0;
    busy_o     = 1'b1;
    case (state_q)
      ST_IDLE:          busy_o     = 1'b0;
      ST_HALT, ST_APPLY: halt_req_o = 1'b1;
      default: begin end
    endcase
  end

  always_comb begin
    lfsr_step   = {1'b0, lfsr_q[RNG_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    lfsr_d      = lfsr_step;
    if (seed_load_i) lfsr_d = (seed_i == '0) ? RNG_WIDTH'(1) : seed_i;

    instr_cnt_d = outst_next(instr_cnt_q, instr_req_i && instr_gnt_i, instr_rvalid_i);
    data_cnt_d  = outst_next(data_cnt_q, data_req_i && data_gnt_i, data_rvalid_i);

    pending_d   = (state_q == ST_IDLE) ? 1'b0 : (pending_q || rekey_req_i);
    period_d    = (period_on && (state_q == ST_IDLE) && !trigger) ?
                  period_q + PERIOD_WIDTH'(1) : '0;

    config_d    = config_q;
    config_d[0] = cfg_enable_i;
    epoch_d     = epoch_q;
    done_d      = (state_q == ST_APPLY);
    if (state_q == ST_APPLY) begin
      config_d[RNG_WIDTH-1:2] = lfsr_q[RNG_WIDTH-1:2];
      config_d[1]             = 1'b0;
      epoch_d                 = epoch_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      instr_cnt_q <= '0;
      data_cnt_q  <= '0;
      period_q    <= '0;
      pending_q   <= 1'b0;
      config_q    <= '0;
      epoch_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      instr_cnt_q <= instr_cnt_d;
      data_cnt_q  <= data_cnt_d;
      period_q    <= period_d;
      pending_q   <= pending_d;
      config_q    <= config_d;
      epoch_q     <= epoch_d;
      done_q      <= done_d;
    end
  end

  assign uaslr_config_o = config_q;
  assign rekey_done_o   = done_q;
  assign epoch_o        = epoch_q;

endmodule

// File: tb/tb_uaslr_rekey_ctrl.sv
// Scoreboard bench for uaslr_rekey_ctrl: a cycle-level reference model pushes the
// expected config/epoch of every applied rekey; a monitor pops on each done pulse.
module tb_uaslr_rekey_ctrl;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int          MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_period = '0;
  logic        rekey_req = 1'b0, seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        ireq = 1'b0, igt = 1'b0, irv = 1'b0;
  logic        dreq = 1'b0, dgt = 1'b0, drv = 1'b0;
  logic        halt_req, halt_ack, done, busy;
  logic [31:0] cfg;
  logic [7:0]  epoch;
  logic        ack_mode = 1'b1;
  logic        ack_dly = 1'b0;
  bit          bus_rand = 1'b0;

  int n_tests = 0, n_fail = 0, n_done = 0;

  always #5 clk = ~clk;

  // Core model: ack either mirrors halt_req combinationally or one cycle late.
  always @(posedge clk) ack_dly <= halt_req;
  assign halt_ack = ack_mode ? ack_dly : halt_req;

  uaslr_rekey_ctrl dut (
    .clk(clk), .rst(rst), .cfg_enable_i(cfg_enable), .cfg_period_i(cfg_period),
    .rekey_req_i(rekey_req), .seed_load_i(seed_load), .seed_i(seed),
    .instr_req_i(ireq), .instr_gnt_i(igt), .instr_rvalid_i(irv),
    .data_req_i(dreq), .data_gnt_i(dgt), .data_rvalid_i(drv),
    .halt_req_o(halt_req), .halt_ack_i(halt_ack), .uaslr_config_o(cfg),
    .rekey_done_o(done), .busy_o(busy), .epoch_o(epoch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] cfg; logic [7:0] epoch; } exp_t;
  exp_t sb_q[$];

  typedef enum int {P_IDLE, P_HALT, P_APPLY, P_RESUME} phase_e;
  phase_e      m_ph = P_IDLE;
  logic [31:0] m_lfsr = SEED;
  logic [31:0] m_cfg = '0;
  int          m_icnt = 0, m_dcnt = 0, m_per = 0, m_epoch = 0;
  bit          m_pend = 0, m_done = 0, m_idle, m_auto, m_trig;

  function automatic int bump(input int c, input bit inc, input bit dec);
    if (inc && !dec) return (c < MAXO) ? c + 1 : MAXO;
    if (dec && !inc) return (c > 0) ? c - 1 : 0;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_lfsr = SEED; m_cfg = '0; m_icnt = 0; m_dcnt = 0;
      m_per = 0; m_epoch = 0; m_pend = 0; m_done = 0;
      sb_q.delete();
    end else begin
      m_idle = (m_ph == P_IDLE);
      m_auto = m_idle && cfg_enable && cfg_period != 0 && m_per == int'(cfg_period) - 1;
      m_trig = m_idle && (rekey_req || m_pend || m_auto);
      m_done = (m_ph == P_APPLY);
      m_cfg[0] = cfg_enable;
      if (m_ph == P_APPLY) begin
        m_cfg[31:1] = {m_lfsr[31:2], 1'b0};
        m_epoch = (m_epoch + 1) % 256;
        sb_q.push_back({m_cfg, 8'(m_epoch)});
      end
      case (m_ph)
        P_IDLE:   if (m_trig) m_ph = P_HALT;
        P_HALT:   if (halt_ack && m_icnt == 0 && m_dcnt == 0) m_ph = P_APPLY;
        P_APPLY:  m_ph = P_RESUME;
        default:  if (!halt_ack) m_ph = P_IDLE;
      endcase
      m_pend = m_idle ? 1'b0 : (m_pend || rekey_req);
      m_per  = (m_idle && cfg_enable && cfg_period != 0 && !m_trig) ? (m_per + 1) % 65536 : 0;
      m_icnt = bump(m_icnt, ireq && igt, irv);
      m_dcnt = bump(m_dcnt, dreq && dgt, drv);
      if (seed_load) m_lfsr = (seed == 0) ? 32'h1 : seed;
      else           m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("halt_req", 32'(halt_req), 32'(m_ph == P_HALT || m_ph == P_APPLY));
    chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
    chk("done", 32'(done), 32'(m_done));
    chk("config", cfg, m_cfg);
    if (done) begin
      n_done++;
      if (sb_q.size() == 0) chk("sb_empty_on_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_config", cfg, e.cfg);
        chk("sb_epoch", 32'(epoch), 32'(e.epoch));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_bus();
    bit halted;
    halted = halt_req || halt_ack;
    ireq = !halted && ($urandom_range(0, 3) == 0);
    igt  = ireq && ($urandom_range(0, 1) == 1);
    irv  = (m_icnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
    dreq = !halted && ($urandom_range(0, 3) == 0);
    dgt  = dreq && ($urandom_range(0, 1) == 1);
    drv  = (m_dcnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus_rand) drive_bus();
  endtask

  task automatic pulse_req();
    rekey_req = 1'b1; cyc(); rekey_req = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_config", cfg, 32'h0);
    chk("reset_epoch", 32'(epoch), 32'h0);
    chk("reset_halt", 32'(halt_req), 32'h0);
    rst = 1'b0;

    // Seeded rekey with one-cycle-late ack.
    cfg_enable = 1'b1; ack_mode = 1'b1;
    seed = 32'h1; seed_load = 1'b1; cyc(); seed_load = 1'b0;
    pulse_req();
    chk("t1_halt_next", 32'(halt_req), 32'h1);
    repeat (10) cyc();
    chk("t1_epoch", 32'(epoch), 32'h1);

    // Two outstanding fetches hold APPLY back until both return.
    ack_mode = 1'b0;
    ireq = 1'b1; igt = 1'b1; cyc(); cyc(); ireq = 1'b0; igt = 1'b0;
    pulse_req();
    repeat (4) cyc();
    chk("t2_held_busy", 32'(busy), 32'h1);
    irv = 1'b1; cyc(); irv = 1'b0;
    repeat (3) cyc();
    chk("t2_still_held", 32'(busy), 32'h1);
    irv = 1'b1; cyc(); irv = 1'b0;
    repeat (6) cyc();
    chk("t2_epoch", 32'(epoch), 32'h2);

    // Periodic rekeys, then period 0 switches them off.
    ack_mode = 1'b1; cfg_period = 16'd10;
    repeat (100) cyc();
    cfg_period = '0;
    repeat (40) cyc();

    // Repeated requests while busy merge into one extra rekey.
    rekey_req = 1'b1; repeat (4) cyc(); rekey_req = 1'b0;
    repeat (25) cyc();

    // Reset during HALT with a data transaction outstanding.
    dreq = 1'b1; dgt = 1'b1; cyc(); dreq = 1'b0; dgt = 1'b0;
    pulse_req();
    repeat (3) cyc();
    chk("t5_busy_before_rst", 32'(busy), 32'h1);
    rst = 1'b1; cyc();
    chk("t5_halt_dropped", 32'(halt_req), 32'h0);
    chk("t5_config_zero", cfg, 32'h0);
    chk("t5_epoch_zero", 32'(epoch), 32'h0);
    rst = 1'b0;
    repeat (3) cyc();
    pulse_req();
    repeat (8) cyc();

    // Same-cycle grant and response keep the data count at 1.
    ack_mode = 1'b0;
    dreq = 1'b1; dgt = 1'b1; cyc();
    drv = 1'b1; cyc();
    dreq = 1'b0; dgt = 1'b0; drv = 1'b0;
    pulse_req();
    repeat (4) cyc();
    chk("t6_held_by_data", 32'(busy), 32'h1);
    drv = 1'b1; cyc(); drv = 1'b0;
    repeat (5) cyc();

    // Zero seed loads as 1; then the epoch wraps on the 256th rekey.
    seed = '0; seed_load = 1'b1; cyc(); seed_load = 1'b0;
    pulse_req(); repeat (6) cyc();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    begin
      int base;
      base = n_done;
      for (int i = 0; i < 255; i++) begin pulse_req(); repeat (5) cyc(); end
      chk("epoch_255", 32'(epoch), 32'd255);
      pulse_req(); repeat (5) cyc();
      chk("epoch_wrap", 32'(epoch), 32'd0);
      chk("wrap_done_count", 32'(n_done - base), 32'd256);
    end

    // Randomised traffic, triggers, seeds, periods and occasional resets.
    bus_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rekey_req = ($urandom_range(0, 24) == 0);
      seed_load = ($urandom_range(0, 59) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 149) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 299) == 0)
        cfg_period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(3, 25));
      if ($urandom_range(0, 99) == 0) ack_mode = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
    end
    bus_rand = 1'b0;
    rekey_req = 1'b0; seed_load = 1'b0; rst = 1'b0;
    ireq = 1'b0; igt = 1'b0; irv = 1'b0; dreq = 1'b0; dgt = 1'b0; drv = 1'b0;
    repeat (20) cyc();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
